// File: rtl/i2c_controller.sv
// rtl/i2c_controller.sv - single-master I2C byte transfer controller with open-drain SCL/SDA
// Optional feature macro: I2C_CLK_STRETCH_EN (peripheral may stretch SCL during the first high quarter).
module i2c_controller #(
   parameter int CLK_DIV = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] tx,
   output logic [7:0] rx,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   inout  wire        scl,
   inout  wire        sda
);
   typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, WDATA, RDATA, DATA_ACK, STOP} state_t;
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   state_t      state;
   logic [15:0] div_cnt;
   logic [1:0]  q;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic [7:0]  tx_r;
   logic        rw_r;
   logic        scl_low;
   logic        sda_low;
   logic        in_bit;
   logic        stall;
   logic        tick;

   assign scl    = scl_low ? 1'b0 : 1'bz;
   assign sda    = sda_low ? 1'b0 : 1'bz;
   assign in_bit = (state == ADDR) || (state == ADDR_ACK) || (state == WDATA) ||
                   (state == RDATA) || (state == DATA_ACK);

`ifdef I2C_CLK_STRETCH_EN
   // The high quarter only starts counting once SCL is actually seen high on the bus.
   assign stall = in_bit && (q == 2'd1) && !scl;
`else
   assign stall = 1'b0;
`endif
   assign tick = (div_cnt == DIV_LAST) && !stall;

   always_ff @(posedge clk) begin
      if (rst || state == IDLE) div_cnt <= '0;
      else if (stall)           div_cnt <= div_cnt;
      else if (tick)            div_cnt <= '0;
      else                      div_cnt <= div_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (rst) begin
         state   <= IDLE;
         q       <= 2'd0;
         bit_cnt <= 3'd0;
         shift   <= 8'd0;
         tx_r    <= 8'd0;
         rw_r    <= 1'b0;
         scl_low <= 1'b0;
         sda_low <= 1'b0;
         busy    <= 1'b0;
         ack_err <= 1'b0;
         rx      <= 8'd0;
      end else if (state == IDLE) begin
         if (start) begin
            state   <= START;
            busy    <= 1'b1;
            ack_err <= 1'b0;
            shift   <= {addr, rw};
            rw_r    <= rw;
            tx_r    <= tx;
            q       <= 2'd0;
            sda_low <= 1'b1;
         end
      end else if (state == START) begin
         if (tick) begin
            if (q == 2'd0) begin
               scl_low <= 1'b1;
               q       <= 2'd1;
            end else begin
               state   <= ADDR;
               q       <= 2'd0;
               bit_cnt <= 3'd0;
               sda_low <= ~shift[7];
            end
         end
      end else if (state == STOP) begin
         if (tick) begin
            case (q)
               2'd0:    begin scl_low <= 1'b0; q <= 2'd1; end
               2'd1:    begin sda_low <= 1'b0; q <= 2'd2; end
               default: begin state <= IDLE; busy <= 1'b0; done <= 1'b1; q <= 2'd0; end
            endcase
         end
      end else if (in_bit && tick) begin
         case (q)
            2'd0: begin scl_low <= 1'b0; q <= 2'd1; end
            2'd1: q <= 2'd2;
            2'd2: begin
               scl_low <= 1'b1;
               q       <= 2'd3;
               if (state == RDATA) shift <= {shift[6:0], sda};
               if (state == ADDR_ACK || (state == DATA_ACK && !rw_r)) ack_err <= sda;
            end
            default: begin
               q <= 2'd0;
               case (state)
                  ADDR, WDATA: begin
                     if (bit_cnt == 3'd7) begin
                        state   <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                        sda_low <= 1'b0;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= {shift[6:0], 1'b0};
                        sda_low <= ~shift[6];
                     end
                  end
                  ADDR_ACK: begin
                     bit_cnt <= 3'd0;
                     if (ack_err) begin
                        state   <= STOP;
                        sda_low <= 1'b1;
                     end else if (rw_r) begin
                        state   <= RDATA;
                        sda_low <= 1'b0;
                     end else begin
                        state   <= WDATA;
                        shift   <= tx_r;
                        sda_low <= ~tx_r[7];
                     end
                  end
                  RDATA: begin
                     if (bit_cnt == 3'd7) state <= DATA_ACK;
                     else                 bit_cnt <= bit_cnt + 3'd1;
                     sda_low <= 1'b0;
                  end
                  default: begin
                     if (rw_r) rx <= shift;
                     state   <= STOP;
                     sda_low <= 1'b1;
                  end
               endcase
            end
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_controller.sv
// tb/tb_i2c_controller.sv - randomized self-checking bench for i2c_controller with a behavioural I2C peripheral
module tb_i2c_controller;
   localparam int CLK_DIV = 4;
   localparam logic [6:0] TARGET = 7'h42;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [6:0] addr = 7'd0;
   logic       rw = 1'b0;
   logic [7:0] tx = 8'd0;
   logic [7:0] rx;
   logic       busy, done, ack_err;
   wire        scl, sda;

   logic per_sda_low = 1'b0;
   logic per_scl_low = 1'b0;
   pullup(scl);
   pullup(sda);
   assign sda = per_sda_low ? 1'b0 : 1'bz;
   assign scl = per_scl_low ? 1'b0 : 1'bz;

   i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .tx(tx),
      .rx(rx), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Peripheral and bus observer state
   int         bitn, byten, pulses, start_cnt, stop_cnt, done_cnt, hi_cnt, txn_cycles;
   logic [7:0] cur;
   logic       addr_hit, rd;
   logic [7:0] resp_byte;
   logic       data_ack_en;
   logic       stretch_req = 1'b0;
   logic [7:0] seen[$];
   int         widths[$];
   logic [7:0] rx_model = 8'd0;

   task automatic clear_monitor();
      bitn = 0; byten = 0; pulses = 0; start_cnt = 0; stop_cnt = 0;
      done_cnt = 0; hi_cnt = 0; addr_hit = 1'b0; rd = 1'b0; per_sda_low = 1'b0;
      seen = {}; widths = {};
   endtask

   always @(negedge sda) if (scl === 1'b1) begin
      start_cnt++; bitn = 0; byten = 0; per_sda_low = 1'b0;
   end
   always @(posedge sda) if (scl === 1'b1) stop_cnt++;

   always @(posedge scl) begin
      if (bitn < 8) cur = {cur[6:0], sda};
      bitn++;
      pulses++;
   end

   always @(negedge scl) begin
      if (bitn == 8) begin
         seen.push_back(cur);
         if (byten == 0) begin
            addr_hit    = (cur[7:1] == TARGET);
            rd          = cur[0];
            per_sda_low = addr_hit;
         end else begin
            per_sda_low = !rd && addr_hit && data_ack_en;
         end
      end else if (bitn == 9) begin
         bitn = 0;
         byten++;
         per_sda_low = rd && addr_hit && (byten == 1) && !resp_byte[7];
         if (stretch_req && byten == 1) begin
            per_scl_low = 1'b1;
            repeat (200) @(posedge clk);
            #1 per_scl_low = 1'b0;
         end
      end else if (bitn >= 1 && bitn <= 7 && rd && addr_hit && byten == 1) begin
         per_sda_low = !resp_byte[7 - bitn];
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (scl === 1'b1) hi_cnt++;
      else if (hi_cnt > 0) begin
         widths.push_back(hi_cnt);
         hi_cnt = 0;
      end
   end

   task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] t,
                          input logic [7:0] resp, input logic dack, input logic mid, input string tag);
      logic [7:0] exp_bytes[$];
      logic       exp_err;
      int         k, bad;
      exp_bytes = {};
      exp_bytes.push_back({a, r});
      if (a == TARGET) exp_bytes.push_back(r ? resp : t);
      exp_err = (a != TARGET) || (!r && !dack);
      if (a == TARGET && r) rx_model = resp;
      resp_byte = resp;
      data_ack_en = dack;
      clear_monitor();
      @(negedge clk);
      addr = a; rw = r; tx = t; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      addr = 7'($urandom); rw = 1'($urandom); tx = 8'($urandom);
      check({tag, "_busy"}, busy, 1);
      k = 0;
      if (mid) begin
         repeat (50) @(negedge clk);
         addr = 7'h10; rw = 1'b1; tx = 8'h55; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         k = 51;
      end
      while (!done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      txn_cycles = k;
      check({tag, "_done"}, done, 1);
      check({tag, "_ack_err"}, ack_err, exp_err);
      check({tag, "_rx"}, rx, rx_model);
      check({tag, "_busy_end"}, busy, 0);
      repeat (3 * CLK_DIV) @(negedge clk);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_starts"}, start_cnt, 1);
      check({tag, "_stops"}, stop_cnt, 1);
      check({tag, "_nbytes"}, seen.size(), exp_bytes.size());
      for (int i = 0; i < seen.size() && i < exp_bytes.size(); i++)
         check({tag, "_byte"}, seen[i], exp_bytes[i]);
      check({tag, "_scl_pulses"}, pulses, 9 * exp_bytes.size() + 1);
      bad = 0;
      for (int i = 1; i < widths.size(); i++) if (widths[i] != 2 * CLK_DIV) bad++;
      check({tag, "_hi_width_bad"}, bad, 0);
      check({tag, "_idle_scl"}, scl, 1);
      check({tag, "_idle_sda"}, sda, 1);
   endtask

   task automatic reset_mid_write();
      int k;
      clear_monitor();
      resp_byte = 8'h00;
      data_ack_en = 1'b1;
      @(negedge clk);
      addr = TARGET; rw = 1'b0; tx = 8'hAA; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(byten == 1 && bitn == 3) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("rst_reach_bit3", k < 3000, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_scl", scl, 1);
      check("rst_mid_sda", sda, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_rx", rx, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_ack_err", ack_err, 0);
      @(negedge clk);
      rst = 1'b0;
      rx_model = 8'd0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      logic [6:0] a;
      clear_monitor();
      resp_byte = 8'h00;
      data_ack_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_ack_err", ack_err, 0);
      check("reset_rx", rx, 0);
      check("reset_scl", scl, 1);
      check("reset_sda", sda, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_txn(TARGET, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0, "write");
      run_txn(TARGET, 1'b1, 8'h00, 8'hAA, 1'b1, 1'b0, "read");
      run_txn(7'h13,  1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, "addr_nack");
      run_txn(TARGET, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b1, "mid_start");
      run_txn(TARGET, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, "data_nack");

      for (int n = 0; n < 8; n++) begin
         a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : TARGET;
         run_txn(a, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'b0, "rand");
      end

      run_txn(TARGET, 1'b1, 8'h00, 8'h5C, 1'b1, 1'b0, "pre_rst_read");
      reset_mid_write();
      run_txn(TARGET, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0, "post_rst_write");

`ifdef I2C_CLK_STRETCH_EN
      stretch_req = 1'b1;
      run_txn(TARGET, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0, "stretch");
      stretch_req = 1'b0;
      check("stretch_waited", txn_cycles > 450, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
